path_deque: RTL and testbench
=============================

// Module: path_deque
// PURPOSE
//  Double-ended queue of 2-bit move directions between the maze-solver controller and path replay.
//  - Search phase: controller pushes each move at the back and pops the back on backtrack
//    (stack use).
//  - Run phase: controller pops the front to replay the path from the start cell (queue use).
//  - Storage is a register-array circular buffer; both ends are readable in the same cycle.
// PARAMETERS
//  DEPTH   256             max stored moves (16x16 maze); must be a power of 2
//  W       2               element width (direction code)
//  PTR_W   $clog2(DEPTH)   derived pointer width; do not override
// PORTS
//  Clk             in   1        rising-edge clock
//  Rst             in   1        synchronous reset, active-high
//  push            in   1        write din at back
//  pop_back        in   1        remove back element
//  pop_front       in   1        remove front element
//  din             in   W        direction to push
//  stack_out       out  W        current back element (top of stack)
//  front_out       out  W        current front element
//  is_deque_empty  out  1        count == 0
//  is_deque_full   out  1        count == DEPTH
//  count           out  PTR_W+1  number of stored elements
//  ovf             out  1        sticky: push refused while full
//  udf             out  1        sticky: pop refused while empty
// BEHAVIOUR
//  - Reset (sync, Rst=1 at the edge):
//    - head=0, tail=0, count=0, ovf=0, udf=0.
//    - Array contents are don't-care.
//    - Rst overrides every op in that cycle.
//  - Pointers:
//    - head indexes the front element; tail indexes the next free slot; both wrap mod DEPTH.
//    - Back element = mem[tail-1].
//  - Outputs:
//    - stack_out and front_out are combinational reads of the registered array (0-cycle read).
//    - Both read 0 when empty; with count==1 they are equal.
//  - Updates take effect at the edge; flags and counts are valid the following cycle.
//  - Single operations:
//    - push: mem[tail]<=din, tail++, count++. When full: ignored, ovf<=1.
//    - pop_back: tail--, count--. When empty: ignored, udf<=1.
//    - pop_front: head++, count--. When empty: ignored, udf<=1.
//  - Simultaneous operations:
//    - push+pop_back:
//      - count>0: mem[tail-1]<=din (replace top); pointers and count unchanged.
//      - empty: acts as plain push.
//    - push+pop_front:
//      - count>0: write at tail, tail++, head++, count unchanged; legal even when full.
//      - empty: plain push, udf<=1.
//    - pop_back+pop_front:
//      - count>=2: tail--, head++, count-=2.
//      - count==1: count->0, head<=tail (one element removed, no udf).
//      - empty: udf<=1.
//    - all three:
//      - count>=2: replace top and head++, count-1.
//      - count==1: plain push of din at a fresh slot, head++ (net count 1, front=din).
//      - empty: plain push, udf<=1.
//  - Flags: ovf and udf stay set until Rst; they never block later legal operations.
//  - Wrap-around: after DEPTH pushes and k pop_fronts, further pushes reuse low slots;
//    tail=DEPTH-1 wraps to 0.
// STRUCTURE
//  - Shared package maze_pkg:
//    - typedef enum logic[1:0] dir_t {UP=2'd0, RIGHT=2'd1, DOWN=2'd2, LEFT=2'd3}
//    - localparam MAZE_CELLS=256
//    - din, stack_out and front_out are typed dir_t.
//  - Sub-module deque_ptr: PTR_W-bit register with sync Rst and inc/dec controls, mod-DEPTH wrap.
//    Instantiated twice, as head and as tail.
//  - Top level holds the array, the count register, the op-decode and the flags.
// TESTING
//  1. Reset, push 1,2,3 -> count=3, stack_out=3, front_out=1, is_deque_empty=0.
//  2. From test 1, pop_back x2 -> stack_out=1, count=1; a 3rd pop_back -> empty.
//     A 4th pop_back -> udf=1, count stays 0.
//  3. Push DEPTH times 0..3 cyclic -> is_deque_full=1.
//     Then push -> ovf=1, count=DEPTH.
//     Then push+pop_front with din=2 -> count=DEPTH, stack_out=2, front_out=1.
//  4. Wrap: push 200, pop_front 150, push 200 -> count=250, tail=144.
//     front_out = element 151 pushed, no ovf.
//  5. count=1 (value 3): push+pop_back din=0 -> count=1, stack_out=0.
//     Then pop_back+pop_front -> empty, udf=0.
//  6. Rst asserted mid-sequence with push=1 -> next cycle count=0, stack_out=0, flags clear.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze-solver types: direction codes and maze geometry.
package maze_pkg;

    localparam int unsigned MAZE_CELLS = 256;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

endpackage

// File: rtl/deque_ptr.sv
// Wrapping deque pointer with synchronous reset; inc and dec together hold the value.
module deque_ptr #(
    parameter int unsigned PTR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Depth is a power of two, so natural overflow gives the mod-DEPTH wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i && !dec_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end else if (dec_i && !inc_i) begin
            ptr_d = ptr_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/path_deque.sv
// Double-ended queue of move directions: stack use during search, queue use during replay.
module path_deque
    import maze_pkg::*;
#(
    parameter int unsigned DEPTH = MAZE_CELLS,
    parameter int unsigned W     = 2,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           push,
    input  logic           pop_back,
    input  logic           pop_front,
    input  dir_t           din,
    output dir_t           stack_out,
    output dir_t           front_out,
    output logic           is_deque_empty,
    output logic           is_deque_full,
    output logic [PTR_W:0] count,
    output logic           ovf,
    output logic           udf
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             udf_q;
    logic             udf_d;

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] tail_m1;
    logic [PTR_W-1:0] wr_addr;
    logic             wr_en;
    logic             head_inc;
    logic             tail_inc;
    logic             tail_dec;
    logic             empty;
    logic             full;
    logic             single;

    assign tail_m1 = tail_ptr - PTR_W'(1);
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign single  = (cnt_q == CNT_W'(1));

    deque_ptr #(.PTR_W(PTR_W)) u_head (
        .clk_i (Clk),
        .rst_i (Rst),
        .inc_i (head_inc),
        .dec_i (1'b0),
        .ptr_o (head_ptr)
    );

    deque_ptr #(.PTR_W(PTR_W)) u_tail (
        .clk_i (Clk),
        .rst_i (Rst),
        .inc_i (tail_inc),
        .dec_i (tail_dec),
        .ptr_o (tail_ptr)
    );

    // Op decode: every combination of push/pop_back/pop_front against empty/single/full.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = tail_ptr;
        head_inc = 1'b0;
        tail_inc = 1'b0;
        tail_dec = 1'b0;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        case ({push, pop_back, pop_front})
            3'b100: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en    = 1'b1;
                    tail_inc = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            3'b010: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    tail_dec = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
            3'b001: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    head_inc = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
            3'b110: begin
                wr_en = 1'b1;
                if (empty) begin
                    tail_inc = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end else begin
                    wr_addr = tail_m1;
                end
            end
            3'b101: begin
                wr_en    = 1'b1;
                tail_inc = 1'b1;
                if (empty) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    udf_d = 1'b1;
                end else begin
                    head_inc = 1'b1;
                end
            end
            3'b011: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else if (single) begin
                    // Advance head onto tail rather than pulling tail back.
                    head_inc = 1'b1;
                    cnt_d    = '0;
                end else begin
                    head_inc = 1'b1;
                    tail_dec = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(2);
                end
            end
            3'b111: begin
                wr_en = 1'b1;
                if (empty) begin
                    tail_inc = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    udf_d    = 1'b1;
                end else if (single) begin
                    tail_inc = 1'b1;
                    head_inc = 1'b1;
                end else begin
                    wr_addr  = tail_m1;
                    head_inc = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Storage has no reset; reset only blocks the write.
    always_ff @(posedge Clk) begin
        if (!Rst && wr_en) begin
            mem_q[wr_addr] <= W'(din);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign stack_out      = empty ? UP : dir_t'(mem_q[tail_m1]);
    assign front_out      = empty ? UP : dir_t'(mem_q[head_ptr]);
    assign is_deque_empty = empty;
    assign is_deque_full  = full;
    assign count          = cnt_q;
    assign ovf            = ovf_q;
    assign udf            = udf_q;

endmodule

// File: tb/tb_path_deque.sv
// Scoreboard bench for path_deque: queue-based reference model, directed scenarios then random ops.
module tb_path_deque;
    import maze_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned W     = 2;
    localparam int unsigned PTR_W = 8;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           push;
    logic           pop_back;
    logic           pop_front;
    dir_t           din;
    dir_t           stack_out;
    dir_t           front_out;
    logic           is_deque_empty;
    logic           is_deque_full;
    logic [PTR_W:0] count;
    logic           ovf;
    logic           udf;

    always #5 Clk = ~Clk;

    path_deque #(.DEPTH(DEPTH), .W(W), .PTR_W(PTR_W)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .push           (push),
        .pop_back       (pop_back),
        .pop_front      (pop_front),
        .din            (din),
        .stack_out      (stack_out),
        .front_out      (front_out),
        .is_deque_empty (is_deque_empty),
        .is_deque_full  (is_deque_full),
        .count          (count),
        .ovf            (ovf),
        .udf            (udf)
    );

    typedef struct {
        int due;
        int cnt;
        int empty;
        int full;
        int stk;
        int frt;
        int ovf;
        int udf;
    } exp_t;

    exp_t sb[$];
    int   mq[$];
    bit   m_ovf;
    bit   m_udf;
    int   edge_cnt = 0;
    int   errors   = 0;
    int   checks   = 0;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    // Reference model: the deque is a plain SV queue, rules taken op-by-op from the behaviour table.
    task automatic model(input bit r, input bit p, input bit pb, input bit pf, input int d);
        int n;
        n = mq.size();
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            case ({p, pb, pf})
                3'b100: if (n == DEPTH) m_ovf = 1'b1; else mq.push_back(d);
                3'b010: if (n == 0) m_udf = 1'b1; else void'(mq.pop_back());
                3'b001: if (n == 0) m_udf = 1'b1; else void'(mq.pop_front());
                3'b110: if (n == 0) mq.push_back(d); else mq[n-1] = d;
                3'b101: begin
                    if (n == 0) m_udf = 1'b1; else void'(mq.pop_front());
                    mq.push_back(d);
                end
                3'b011: begin
                    if (n == 0) m_udf = 1'b1;
                    else if (n == 1) mq.delete();
                    else begin
                        void'(mq.pop_back());
                        void'(mq.pop_front());
                    end
                end
                3'b111: begin
                    if (n == 0) begin
                        mq.push_back(d);
                        m_udf = 1'b1;
                    end else if (n == 1) begin
                        void'(mq.pop_front());
                        mq.push_back(d);
                    end else begin
                        mq[n-1] = d;
                        void'(mq.pop_front());
                    end
                end
                default: begin
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the coming edge.
    task automatic step(input bit r, input bit p, input bit pb, input bit pf, input int d);
        exp_t e;
        int   dv;
        dv        = d & 3;
        Rst       = r;
        push      = p;
        pop_back  = pb;
        pop_front = pf;
        din       = dir_t'(2'(dv));
        model(r, p, pb, pf, dv);
        e.due   = edge_cnt + 1;
        e.cnt   = mq.size();
        e.empty = (mq.size() == 0) ? 1 : 0;
        e.full  = (mq.size() == DEPTH) ? 1 : 0;
        e.stk   = (mq.size() > 0) ? mq[mq.size()-1] : 0;
        e.frt   = (mq.size() > 0) ? mq[0] : 0;
        e.ovf   = int'(m_ovf);
        e.udf   = int'(m_udf);
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    // Monitor: outputs are always valid, so each entry is compared at the negedge after its edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                e = sb.pop_front();
                chk("count",     int'(count),          e.cnt);
                chk("empty",     int'(is_deque_empty), e.empty);
                chk("full",      int'(is_deque_full),  e.full);
                chk("stack_out", int'(stack_out),      e.stk);
                chk("front_out", int'(front_out),      e.frt);
                chk("ovf",       int'(ovf),            e.ovf);
                chk("udf",       int'(udf),            e.udf);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; push = 1'b0; pop_back = 1'b0; pop_front = 1'b0; din = UP;
        @(posedge Clk);
        #1;

        // Reset, then push 1,2,3 and pop_back down past empty.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 2);
        step(0, 1, 0, 0, 3);
        repeat (4) step(0, 0, 1, 0, 0);

        // Fill to DEPTH, overflow, then push+pop_front while full.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, i % 4);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 1, 2);

        // Reset with push asserted while flags are set.
        step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 3);
        step(0, 0, 0, 0, 0);

        // Wrap-around: 200 pushes, 150 pop_fronts, 200 pushes.
        for (int i = 0; i < 200; i++) step(0, 1, 0, 0, int'($urandom_range(0, 3)));
        for (int i = 0; i < 150; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 200; i++) step(0, 1, 0, 0, int'($urandom_range(0, 3)));

        // Single element: replace top, then pop both ends.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 3);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        // Combined ops on empty and single-element deques.
        step(0, 1, 1, 1, 2);
        step(0, 1, 1, 1, 1);
        step(0, 1, 0, 1, 3);
        step(0, 0, 1, 1, 0);
        step(0, 1, 0, 1, 2);

        // Random traffic, push-biased in bursts so the deque visits full and empty.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bit r;
            bit p;
            bit pb;
            bit pf;
            bias = ((i / 400) % 2 == 0) ? 75 : 30;
            r    = ($urandom_range(0, 499) == 0);
            p    = ($urandom_range(0, 99) < bias);
            pb   = ($urandom_range(0, 99) < 25);
            pf   = ($urandom_range(0, 99) < 25);
            step(r, p, pb, pf, int'($urandom_range(0, 3)));
        end

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (4) @(negedge Clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
